freq_packetizer: RTL and testbench

Downstream stage of the frequency selector: consumes the 80-bit tagged samples it emits (`data_out`/`index_out`/`valid_out`) and frames them into a 128-bit AXI4-Stream for the DMA. Input has no back-pressure, so samples are buffered in an internal FIFO. A frame (header + `FRAME_LEN` samples) is emitted only once it is fully buffered. Samples arriving while the FIFO is full are dropped, and the drops are reported in the next header.

---
 rtl/freq_packetizer.sv | 211 +++++++++++++++++++++
 tb/tb_freq_packetizer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_packetizer.sv
// freq_packetizer: buffers tagged samples from the frequency selector in a
// FIFO and frames them into a 128-bit AXI4-Stream (header + FRAME_LEN words).
// A frame is started only once FRAME_LEN samples are buffered, so the payload
// never waits on input. Samples that arrive while the FIFO is full are dropped
// and counted; the count is reported in the next header.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | output empty; waiting for a full frame's worth of samples
// ST_HEADER  | header word held on the stream until accepted
// ST_PAYLOAD | sample words streamed from the FIFO head, tlast on the final

module freq_packetizer #(
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic              dev_clk,
    input  logic              dev_rst,
    input  logic              en,
    input  logic [79:0]       data_in,
    input  logic [6:0]        index_in,
    input  logic              valid_in,
    output logic [127:0]      m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam logic [31:0]      MAGIC     = 32'h4653_4C31;
    localparam logic [15:0]      LEN_FIELD = 16'(FRAME_LEN);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LEN_CNT   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // sample storage and FIFO bookkeeping
    logic [86:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // framing state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]      seq_q, seq_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    // stream output register
    logic [127:0]     tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;

    logic             capture;
    logic             fifo_full;
    logic             push;
    logic             drop;
    logic             fire;
    logic             hdr_fire;
    logic             pay_fire;
    logic             pop;
    logic [86:0]      head;

    // Write/drop decision uses only the registered count: a pop on the same
    // edge never frees room for a write that sees the FIFO full.
    always_comb begin
        capture   = valid_in && en;
        fifo_full = (count_q == DEPTH_CNT);
        push      = capture && !fifo_full;
        drop      = capture && fifo_full;
        fire      = tvalid_q && m_axis_tready;
        hdr_fire  = fire && (state_q == ST_HEADER);
        pay_fire  = fire && (state_q == ST_PAYLOAD);
        // The header handshake preloads the first sample; each accepted
        // non-final payload word preloads the next one.
        pop       = hdr_fire || (pay_fire && !tlast_q);
        head      = mem_q[rd_ptr_q];
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Drop accounting: the counter restarts when a header is accepted, so a
    // drop on that very edge is the first one of the new reporting window.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q | drop;
        if (hdr_fire) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Framing FSM and output register next-state
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        seq_d      = seq_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q >= LEN_CNT) begin
                    tdata_d  = {MAGIC, seq_q, LEN_FIELD, drop_cnt_q, 32'h0};
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (fire) begin
                    tdata_d    = {41'd0, head};
                    tlast_d    = (LAST_IDX == '0);
                    word_cnt_d = '0;
                    seq_d      = seq_q + 32'd1;
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (fire) begin
                    word_cnt_d = word_cnt_q + CNT_ONE;
                    if (tlast_q) begin
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        tdata_d = {41'd0, head};
                        tlast_d = ((word_cnt_q + CNT_ONE) == LAST_IDX);
                    end
                end
            end
            default: begin
                tdata_d  = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Sample memory: contents need no reset, occupancy is tracked by count_q
    always_ff @(posedge dev_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {index_in, data_in};
        end
    end

    // State registers; reset abandons any partial frame without a tlast
    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_freq_packetizer.sv
// Testbench for freq_packetizer: directed scenarios plus a randomized run,
// all checked cycle by cycle against a queue-based behavioural model.

module tb_freq_packetizer;

    localparam int FRAME_LEN  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;
    localparam logic [31:0] MAGIC = 32'h4653_4C31;

    logic             dev_clk = 1'b0;
    logic             dev_rst;
    logic             en;
    logic [79:0]      data_in;
    logic [6:0]       index_in;
    logic             valid_in;
    logic [127:0]     m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model: queue of buffered samples plus the stream word on offer
    logic [86:0]  mq[$];
    int           m_phase;   // 0 waiting, 1 header offered, 2 payload offered
    int           m_sent;
    int           m_drop;
    logic [31:0]  m_seq;
    bit           m_valid;
    bit           m_last;
    bit           m_ovf;
    logic [127:0] m_data;

    // words observed crossing the stream interface
    logic [127:0] obs_data[$];
    bit           obs_last[$];

    logic [79:0] sd[12];
    logic [6:0]  si[12];
    bit          bp[4];
    int          cyc;

    freq_packetizer #(
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .dev_clk       (dev_clk),
        .dev_rst       (dev_rst),
        .en            (en),
        .data_in       (data_in),
        .index_in      (index_in),
        .valid_in      (valid_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 dev_clk = ~dev_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] hdr_word(input logic [31:0] seq, input logic [15:0] drops);
        return {MAGIC, seq, 16'(FRAME_LEN), drops, 32'h0};
    endfunction

    function automatic logic [127:0] smp_word(input logic [6:0] idx, input logic [79:0] dat);
        return {41'd0, idx, dat};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_sent  = 0;
        m_drop  = 0;
        m_seq   = 0;
        m_valid = 0;
        m_last  = 0;
        m_ovf   = 0;
        m_data  = '0;
    endtask

    // one clock edge of the model, from the inputs the bench is driving
    task automatic model_step();
        int sz;
        bit cap;
        bit fire;
        bit hdr_fire;
        sz       = mq.size();
        cap      = valid_in && en;
        fire     = m_valid && m_axis_tready;
        hdr_fire = fire && (m_phase == 1);
        if (m_phase == 0) begin
            if (sz >= FRAME_LEN) begin
                m_data  = hdr_word(m_seq, 16'(m_drop));
                m_valid = 1;
                m_last  = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (fire) begin
                m_data  = {41'd0, mq.pop_front()};
                m_seq   = m_seq + 1;
                m_sent  = 0;
                m_last  = (FRAME_LEN == 1);
                m_phase = 2;
            end
        end else if (fire) begin
            if (m_last) begin
                m_valid = 0;
                m_last  = 0;
                m_phase = 0;
            end else begin
                m_data = {41'd0, mq.pop_front()};
                m_sent = m_sent + 1;
                m_last = (m_sent == FRAME_LEN - 1);
            end
        end
        if (hdr_fire)
            m_drop = (cap && sz == FIFO_DEPTH) ? 1 : 0;
        else if (cap && sz == FIFO_DEPTH && m_drop < 65535)
            m_drop = m_drop + 1;
        if (cap && sz == FIFO_DEPTH) m_ovf = 1;
        if (cap && sz < FIFO_DEPTH) mq.push_back({index_in, data_in});
    endtask

    task automatic check_outputs();
        chk("tvalid", m_axis_tvalid, m_valid);
        chk("tlast", m_axis_tlast, m_last);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
        if (m_valid) chk("tdata", m_axis_tdata, m_data);
    endtask

    // called at a negedge with inputs set for the coming edge
    task automatic tick();
        if (m_axis_tvalid && m_axis_tready) begin
            obs_data.push_back(m_axis_tdata);
            obs_last.push_back(m_axis_tlast);
        end
        @(posedge dev_clk);
        model_step();
        @(negedge dev_clk);
        check_outputs();
    endtask

    task automatic push(input logic [6:0] idx, input logic [79:0] dat);
        index_in = idx;
        data_in  = dat;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k;
        k = 0;
        while (obs_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_obs", obs_data.size() >= n, 1'b1);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        dev_rst  = 1'b1;
        model_reset();
        obs_data.delete();
        obs_last.delete();
        @(posedge dev_clk);
        @(negedge dev_clk);
        dev_rst = 1'b0;
        check_outputs();
    endtask

    function automatic logic [79:0] rnd_data();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    initial begin
        dev_rst       = 1'b0;
        en            = 1'b1;
        valid_in      = 1'b0;
        data_in       = '0;
        index_in      = '0;
        m_axis_tready = 1'b0;
        bp[0] = 1'b1; bp[1] = 1'b0; bp[2] = 1'b0; bp[3] = 1'b1;
        model_reset();
        #1 dev_rst = 1'b1;
        @(negedge dev_clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 128'd0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        dev_rst = 1'b0;

        // basic frame: index 0..3, data = index * 0x1111
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) push(7'(i), 80'(i * 32'h1111));
        wait_obs(5, 20);
        chk("basic_hdr", obs_data[0], hdr_word(32'd0, 16'd0));
        chk("basic_hdr_last", obs_last[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("basic_word", obs_data[i+1], smp_word(7'(i), 80'(i * 32'h1111)));
            chk("basic_last", obs_last[i+1], (i == 3));
        end
        tick();
        tick();
        chk("basic_empty", fifo_count, 0);

        // back-pressure: tready 1,0,0,1,... over two frames
        do_reset();
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            si[i] = 7'($urandom());
            sd[i] = rnd_data();
            m_axis_tready = bp[cyc % 4];
            push(si[i], sd[i]);
            cyc++;
        end
        for (int k = 0; k < 80 && obs_data.size() < 10; k++) begin
            m_axis_tready = bp[cyc % 4];
            tick();
            cyc++;
        end
        chk("bp_words", obs_data.size(), 10);
        chk("bp_hdr0", obs_data[0], hdr_word(32'd0, 16'd0));
        chk("bp_hdr1", obs_data[5], hdr_word(32'd1, 16'd0));
        for (int i = 0; i < 4; i++) begin
            chk("bp_f0_word", obs_data[i+1], smp_word(si[i], sd[i]));
            chk("bp_f1_word", obs_data[i+6], smp_word(si[i+4], sd[i+4]));
        end
        chk("bp_last0", obs_last[4], 1'b1);
        chk("bp_last1", obs_last[9], 1'b1);

        // overflow with tready low, then a push at full on the header handshake
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            si[i] = 7'($urandom());
            sd[i] = rnd_data();
            push(si[i], sd[i]);
        end
        chk("ovf_count", fifo_count, FIFO_DEPTH);
        chk("ovf_flag", overflow, 1'b1);
        m_axis_tready = 1'b1;
        push(7'h55, rnd_data());
        chk("ovf_pop_count", fifo_count, 7);
        wait_obs(10, 40);
        chk("ovf_hdr0", obs_data[0], hdr_word(32'd0, 16'd0));
        chk("ovf_hdr1", obs_data[5], hdr_word(32'd1, 16'd1));
        for (int i = 0; i < 4; i++) begin
            chk("ovf_f0_word", obs_data[i+1], smp_word(si[i], sd[i]));
            chk("ovf_f1_word", obs_data[i+6], smp_word(si[i+4], sd[i+4]));
        end
        tick();
        chk("ovf_drained", fifo_count, 0);

        // enable gating: nothing captured, nothing dropped
        do_reset();
        en = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(7'(i), rnd_data());
        chk("en_count", fifo_count, 0);
        chk("en_overflow", overflow, 1'b0);
        chk("en_tvalid", m_axis_tvalid, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) push(7'(i), rnd_data());
        en = 1'b0;
        for (int i = 0; i < 5; i++) push(7'(i), rnd_data());
        chk("en_full_count", fifo_count, FIFO_DEPTH);
        chk("en_full_overflow", overflow, 1'b0);
        en = 1'b1;
        m_axis_tready = 1'b1;
        wait_obs(10, 40);
        chk("en_hdr1", obs_data[5], hdr_word(32'd1, 16'd0));

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en            = ($urandom_range(0, 9) != 0);
            valid_in      = ($urandom_range(0, 2) != 0);
            index_in      = 7'($urandom());
            data_in       = rnd_data();
            m_axis_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_in      = 1'b0;
        m_axis_tready = 1'b1;
        repeat (30) tick();

        // asynchronous reset while payload word 2 of 4 is on offer
        do_reset();
        en = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) push(7'(i), rnd_data());
        wait_obs(3, 20);
        chk("mid_pre_tvalid", m_axis_tvalid, 1'b1);
        #2 dev_rst = 1'b1;
        #1;
        chk("mid_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_tlast", m_axis_tlast, 1'b0);
        chk("mid_count", fifo_count, 0);
        chk("mid_tdata", m_axis_tdata, 128'd0);
        model_reset();
        obs_data.delete();
        obs_last.delete();
        @(negedge dev_clk);
        dev_rst = 1'b0;
        for (int i = 0; i < 4; i++) push(7'(i + 8), rnd_data());
        wait_obs(5, 20);
        chk("mid_next_hdr", obs_data[0], hdr_word(32'd0, 16'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
